// File: rtl/da_pkg.sv
// da_pkg: shared constants, FSM state type and Gray helper for the DA table loader
package da_pkg;
   localparam int NROM    = 8;
   localparam int ROM_AW  = 8;
   localparam int NTAPS   = NROM * ROM_AW;
   localparam int COEF_W  = 16;
   localparam int CIN_W   = 20;
   localparam int CADDR_W = 11;
   typedef enum logic [1:0] {IDLE, COLLECT, GEN} state_e;
   function automatic logic [ROM_AW-1:0] gray(input logic [ROM_AW-1:0] n);
      return n ^ (n >> 1);
   endfunction
endpackage

// File: rtl/da_rom_loader_if.sv
// da_rom_loader_if: coefficient stream in, DA table load port out (checksum port with DA_ROM_LOADER_CHECKSUM_EN)
interface da_rom_loader_if;
   import da_pkg::*;
   logic                       cfg_start;
   logic signed [COEF_W-1:0]   coef_in;
   logic                       coef_valid;
   logic                       coef_ready;
   logic        [CADDR_W-1:0]  CADDR;
   logic signed [CIN_W-1:0]    CIN;
   logic                       CLOAD;
   logic                       valid_in;
   logic                       busy;
   logic                       load_done;
   logic                       da_start;
`ifdef DA_ROM_LOADER_CHECKSUM_EN
   logic        [31:0]         checksum;
   modport master (input cfg_start, coef_in, coef_valid,
                   output coef_ready, CADDR, CIN, CLOAD, valid_in, busy, load_done, da_start, checksum);
   modport slave  (output cfg_start, coef_in, coef_valid,
                   input coef_ready, CADDR, CIN, CLOAD, valid_in, busy, load_done, da_start, checksum);
`else
   modport master (input cfg_start, coef_in, coef_valid,
                   output coef_ready, CADDR, CIN, CLOAD, valid_in, busy, load_done, da_start);
   modport slave  (output cfg_start, coef_in, coef_valid,
                   input coef_ready, CADDR, CIN, CLOAD, valid_in, busy, load_done, da_start);
`endif
endinterface

// File: rtl/da_gray_step.sv
// da_gray_step: 8-bit step counter giving the next Gray address, its flipped bit and direction
import da_pkg::*;
module da_gray_step (
   input  logic              clk,
   input  logic              resetn,
   input  logic              clr_i,
   input  logic              en_i,
   output logic [ROM_AW-1:0] a_o,
   output logic [2:0]        b_o,
   output logic              add_o,
   output logic              wrap_o
);
   logic [ROM_AW-1:0] n_q, n_d;
   assign n_d    = n_q + 1'b1;
   assign a_o    = gray(n_d);
   assign add_o  = a_o[b_o];
   assign wrap_o = &n_q;
   // lowest set bit of the next count is the Gray bit that flips
   always_comb begin
      b_o = '0;
      for (int i = ROM_AW - 1; i >= 0; i--) if (n_d[i]) b_o = 3'(i);
   end
   // position within the current ROM
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) n_q <= '0;
      else if (clr_i) n_q <= '0;
      else if (en_i) n_q <= n_d;
endmodule

// File: rtl/da_rom_loader.sv
// da_rom_loader: collects 64 taps and writes the 8x256 DA partial-sum tables (checksum with DA_ROM_LOADER_CHECKSUM_EN)
import da_pkg::*;
module da_rom_loader (
   input  logic          clk,
   input  logic          resetn,
   da_rom_loader_if.master bus
);
   state_e                    state_q;
   logic [5:0]                tap_q;
   logic [2:0]                rom_q;
   logic [CADDR_W-1:0]        caddr_q;
   logic signed [CIN_W-1:0]   cin_q;
   logic                      cload_q, done_q, start_q;
   logic signed [COEF_W-1:0]  coef_q [NTAPS];
   logic [ROM_AW-1:0]         a_nx;
   logic [2:0]                b_nx;
   logic                      add_nx, wrap;
   logic signed [COEF_W-1:0]  coef_sel;
   logic signed [CIN_W-1:0]   coef_ext;
   logic                      accept, begin_load;
   assign accept     = (state_q == COLLECT) && bus.coef_valid;
   assign begin_load = (state_q == IDLE) && bus.cfg_start;
   assign coef_sel   = coef_q[{rom_q, b_nx}];
   assign coef_ext   = {{(CIN_W-COEF_W){coef_sel[COEF_W-1]}}, coef_sel};
   da_gray_step u_step (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (begin_load),
      .en_i   (state_q == GEN),
      .a_o    (a_nx),
      .b_o    (b_nx),
      .add_o  (add_nx),
      .wrap_o (wrap)
   );
   // tap register file, deliberately unreset
   always_ff @(posedge clk)
      if (accept) coef_q[tap_q] <= bus.coef_in;
   // control FSM with registered load-port outputs; s is kept directly in cin_q
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         tap_q   <= '0;
         rom_q   <= '0;
         caddr_q <= '0;
         cin_q   <= '0;
         cload_q <= 1'b0;
         done_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.cfg_start) begin
               state_q <= COLLECT;
               start_q <= 1'b0;
               tap_q   <= '0;
            end
            COLLECT: if (bus.coef_valid) begin
               tap_q <= tap_q + 1'b1;
               if (&tap_q) begin
                  state_q <= GEN;
                  rom_q   <= '0;
                  caddr_q <= '0;
                  cin_q   <= '0;
                  cload_q <= 1'b1;
               end
            end
            GEN: if (wrap && &rom_q) begin
               state_q <= IDLE;
               caddr_q <= '0;
               cin_q   <= '0;
               cload_q <= 1'b0;
               done_q  <= 1'b1;
               start_q <= 1'b1;
            end else if (wrap) begin
               rom_q   <= rom_q + 1'b1;
               caddr_q <= {rom_q + 1'b1, 8'h00};
               cin_q   <= '0;
            end else begin
               caddr_q <= {rom_q, a_nx};
               cin_q   <= add_nx ? cin_q + coef_ext : cin_q - coef_ext;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.coef_ready = state_q == COLLECT;
   assign bus.busy       = (state_q == COLLECT) || (state_q == GEN);
   assign bus.CADDR      = caddr_q;
   assign bus.CIN        = cin_q;
   assign bus.CLOAD      = cload_q;
   assign bus.valid_in   = cload_q;
   assign bus.load_done  = done_q;
   assign bus.da_start   = start_q;
`ifdef DA_ROM_LOADER_CHECKSUM_EN
   logic [31:0] sum_q;
   // wrapping sum of every written word, restarted when a reload is accepted
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) sum_q <= '0;
      else if (begin_load) sum_q <= '0;
      else if (cload_q) sum_q <= sum_q + {{(32-CIN_W){cin_q[CIN_W-1]}}, cin_q};
   assign bus.checksum = sum_q;
`endif
endmodule

// File: tb/tb_da_rom_loader.sv
// tb_da_rom_loader: directed self-checking bench for da_rom_loader
module tb_da_rom_loader;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int total = 0;
   int bad = 0;
   logic signed [15:0] taps [64];
   logic [19:0] tbl [2048];
   logic [10:0] f_addr [4];
   logic [19:0] f_cin [4];
   logic [10:0] last_addr;
   int writes, rdy, idx, pc_err, done_seen;

   da_rom_loader_if bus ();
   da_rom_loader dut (.clk(clk), .resetn(resetn), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_cload"}, bus.CLOAD, 0);
      chk({tag, "_valid_in"}, bus.valid_in, 0);
      chk({tag, "_ready"}, bus.coef_ready, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_da_start"}, bus.da_start, 0);
      chk({tag, "_caddr"}, bus.CADDR, 0);
      chk({tag, "_cin"}, bus.CIN == 0, 1);
   endtask

   task automatic load(input bit gap, input bit hold_cfg);
      int cyc = 0;
      bit ph = 1'b0;
      @(negedge clk);
      bus.cfg_start = 1'b1;
      @(negedge clk);
      bus.cfg_start = hold_cfg;
      chk("da_start_drop", bus.da_start, 0);
      chk("busy_collect", bus.busy, 1);
      idx = 0;
      rdy = 0;
      while (idx < 64 && cyc < 500) begin
         if (bus.coef_ready) rdy++;
         bus.coef_valid = gap ? ph : 1'b1;
         ph = ~ph;
         bus.coef_in = taps[idx];
         if (bus.coef_valid && bus.coef_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      bus.coef_valid = 1'b0;
      bus.cfg_start = 1'b0;
      chk("accepts", idx, 64);
      chk("ready_off", bus.coef_ready, 0);
   endtask

   task automatic capture(input int stop_at);
      int cyc = 0;
      writes = 0;
      done_seen = 0;
      for (int i = 0; i < 2048; i++) tbl[i] = 20'hxxxxx;
      while (done_seen == 0 && cyc < 3000 && !(stop_at > 0 && writes == stop_at)) begin
         if (bus.CLOAD) begin
            tbl[bus.CADDR] = bus.CIN;
            if (writes < 4) begin
               f_addr[writes] = bus.CADDR;
               f_cin[writes] = bus.CIN;
            end
            last_addr = bus.CADDR;
            writes++;
         end else if (bus.load_done) begin
            done_seen = 1;
         end else begin
            chk("gen_bubble", bus.CLOAD, 1);
         end
         if (done_seen == 0 && !(stop_at > 0 && writes == stop_at)) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (stop_at == 0) chk("done_timeout", done_seen, 1);
   endtask

   task automatic check_done;
      chk("writes", writes, 2048);
      chk("last_addr", last_addr, 11'h780);
      chk("done_cload", bus.CLOAD, 0);
      chk("done_caddr", bus.CADDR, 0);
      chk("done_cin", bus.CIN == 0, 1);
      chk("done_da_start", bus.da_start, 1);
      chk("done_busy", bus.busy, 0);
      @(negedge clk);
      chk("done_pulse_one", bus.load_done, 0);
      chk("da_start_hold", bus.da_start, 1);
   endtask

   task automatic popcount_check(input string tag);
      pc_err = 0;
      for (int i = 0; i < 2048; i++) begin
         logic [7:0] a;
         a = 8'(i);
         if (tbl[i] !== 20'($countones(a))) pc_err++;
      end
      chk(tag, pc_err, 0);
   endtask

   initial begin
      bus.cfg_start = 1'b0;
      bus.coef_in = '0;
      bus.coef_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      resetn = 1'b1;
      @(negedge clk);
      bus.coef_valid = 1'b1;
      @(negedge clk);
      chk("idle_ignores_valid", bus.busy, 0);
      bus.coef_valid = 1'b0;

      for (int t = 0; t < 64; t++) taps[t] = 16'sd1;
      load(1'b0, 1'b0);
      chk("ready_cycles_cont", rdy, 64);
      capture(0);
      chk("w0_addr", f_addr[0], 11'h000);
      chk("w0_cin", f_cin[0], 20'd0);
      chk("w1_addr", f_addr[1], 11'h001);
      chk("w1_cin", f_cin[1], 20'd1);
      chk("w2_addr", f_addr[2], 11'h003);
      chk("w2_cin", f_cin[2], 20'd2);
      chk("w3_addr", f_addr[3], 11'h002);
      chk("w3_cin", f_cin[3], 20'd1);
`ifdef DA_ROM_LOADER_CHECKSUM_EN
      chk("checksum", bus.checksum, 32'd8192);
`endif
      check_done();
      popcount_check("ones_table");

      for (int t = 0; t < 64; t++) taps[t] = 16'(t + 1);
      load(1'b0, 1'b1);
      capture(0);
      check_done();
      chk("ramp_7ff", tbl[11'h7FF], 20'd484);
      chk("ramp_0ff", tbl[11'h0FF], 20'd36);
      chk("ramp_101", tbl[11'h101], 20'd9);

      for (int t = 0; t < 64; t++) taps[t] = 16'sh8000;
      load(1'b0, 1'b0);
      capture(0);
      check_done();
      chk("neg_0ff", tbl[11'h0FF], 20'hC0000);
      chk("neg_001", tbl[11'h001], 20'hF8000);

      for (int t = 0; t < 64; t++) taps[t] = 16'sd1;
      load(1'b1, 1'b0);
      chk("ready_cycles_gap", rdy, 128);
      capture(0);
      check_done();
      popcount_check("gap_table");

      load(1'b0, 1'b0);
      capture(1000);
      chk("pre_reset_writes", writes, 1000);
      resetn = 1'b0;
      #1;
      chk_idle_outputs("midreset");
      chk("midreset_done", bus.load_done, 0);
      @(negedge clk);
      resetn = 1'b1;
      done_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.load_done || bus.CLOAD) done_seen = 1;
      end
      chk("no_done_after_reset", done_seen, 0);
      load(1'b0, 1'b0);
      capture(0);
      check_done();
      popcount_check("reload_table");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
